digest_serializer: RTL and testbench
====================================

Name: digest_serializer

Overview:
- Parallel-in, serial-out transmitter for the cSHAKE256 digest.
- Accepts the OUT_BITS-wide digest when the hash core asserts done, then shifts it out one bit per accepted cycle.
- Marks the final bit with serial_end_signal.
- It is the transmit-side counterpart of the core's serial_in / serial_end_signal / enable input interface, so two cores or a core and a host bench can be chained bit-serially.

Parameters:
- OUT_BITS, 512, digest width in bits; must be >= 2.
- CNT_W, $clog2(OUT_BITS), bit counter width.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  capture request; tie to hash core done
- digest_in  input  OUT_BITS  digest to transmit, sampled when load is accepted
- load_ready  output  1  high in IDLE only; load accepted when load && load_ready
- enable  input  1  downstream ready; a bit transfers on a cycle with serial_valid && enable
- serial_out  output  1  current data bit
- serial_valid  output  1  serial_out is valid
- serial_end_signal  output  1  high with the last bit (index OUT_BITS-1)
- tx_done  output  1  one-cycle pulse after the last bit transfers
- debug_ser_state  output  2  FSM state encoding
- debug_ser_bitcount  output  CNT_W  bits already transferred

Behaviour:
- Reset (synchronous, active-high; wins over every other input):
  - state = IDLE; shift register and bit counter cleared.
  - load_ready = 1; serial_out, serial_valid, serial_end_signal and tx_done = 0.
- Moore outputs decode from registered state/shreg/count; there is no combinational path from enable or load to any output.
- States: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2; 2'd3 is illegal and returns to IDLE.
- IDLE:
  - load_ready = 1.
  - On load: shreg <= digest_in; bitcount <= 0; go to SHIFT.
  - Without load: stay.
- SHIFT:
  - serial_valid = 1; serial_out = shreg[0] (LSB-first, matching the Keccak lane byte/bit order).
  - serial_end_signal = (bitcount == OUT_BITS-1).
  - On enable: shreg shifts right by 1 with zero fill; bitcount increments.
    - If bitcount == OUT_BITS-1 at that handshake, go to DONE.
  - On !enable: hold shreg, bitcount and outputs unchanged (bit repeats).
- DONE:
  - tx_done = 1 for exactly one cycle; serial_valid = 0.
  - Unconditionally go to IDLE; load is not accepted in DONE.
- Latency and throughput:
  - First bit is valid the cycle after load is accepted.
  - With enable held high, load at edge 0 gives bits on cycles 1..OUT_BITS, tx_done on cycle OUT_BITS+1, and load_ready again on cycle OUT_BITS+2.
  - Throughput is 1 bit/cycle.
- load while not in IDLE: ignored; digest_in is not sampled.
- Reset mid-transfer: the next cycle is IDLE with all outputs at reset values; no serial_end_signal and no tx_done are emitted for the aborted frame.
- bitcount never exceeds OUT_BITS-1 and does not wrap.

Optional Feature:
- DIGEST_SER_MSB_FIRST_EN
  - Defined: serial_out = shreg[OUT_BITS-1]; the shift is left with zero fill.
  - Undefined (default): LSB-first as above.
  - State machine, counter, handshake and timing are identical in both builds.

Decomposition:
- Shared package cshake_pkg:
  - OUT_BITS default (512).
  - Serializer state localparams SER_IDLE, SER_SHIFT, SER_DONE.
- One natural sub-module, piso_shift_reg:
  - Parameterized OUT_BITS parallel-load shift register.
  - Inputs load, shift_en, par_in; output ser_out.
  - Direction selected by the macro.
- The FSM and counter stay in digest_serializer.

Test Plan:
- Basic frame:
  - Stimulus: digest_in = 512'h1, load pulse, enable held 1.
  - Response: first serial_out = 1, then 511 zeros; serial_end_signal only on bit 511; tx_done on cycle 513; load_ready high on cycle 514.
- Pattern and end marker:
  - Stimulus: digest_in = {256'h0, 256'hFFFF...F}.
  - Response: bits 0–255 = 1, bits 256–511 = 0; debug_ser_bitcount reaches 511 with serial_end_signal high.
- Backpressure:
  - Stimulus: enable toggling 1,0,1,0…
  - Response: each bit is held two cycles; the frame completes with tx_done on cycle 1025; bit sequence is identical to the basic frame.
- Load collision:
  - Stimulus: second load with digest_in = 512'hA5 asserted on cycle 50 of an active frame.
  - Response: ignored; the original digest continues uncorrupted; load_ready stays 0 until IDLE.
- Reset mid-frame:
  - Stimulus: reset at bitcount = 100.
  - Response: next cycle serial_valid = 0, load_ready = 1, debug_ser_state = 0; no tx_done; a new load afterwards transmits cleanly.
- MSB-first build:
  - Stimulus: with DIGEST_SER_MSB_FIRST_EN defined, digest_in = 512'h8000…0 (MSB set).
  - Response: first bit = 1, remaining 511 = 0; timing matches the basic frame.

Source files
------------

// File: rtl/cshake_pkg.sv
// cshake_pkg -- definitions shared by the cSHAKE256 digest serializer files.
//   OUT_BITS_DEFAULT : default digest width in bits (512).
//   SER_IDLE/SER_SHIFT/SER_DONE : serializer FSM encodings, also seen on
//                                 debug_ser_state.
//   ser_state_e      : typed FSM state built on those encodings.
// Macro DIGEST_SER_MSB_FIRST_EN (optional) selects MSB-first transmission;
// it does not change anything in this package.
package cshake_pkg;

    localparam int OUT_BITS_DEFAULT = 512;

    localparam logic [1:0] SER_IDLE  = 2'd0;
    localparam logic [1:0] SER_SHIFT = 2'd1;
    localparam logic [1:0] SER_DONE  = 2'd2;

    // 2'd3 is never entered on purpose; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = SER_IDLE,
        ST_SHIFT   = SER_SHIFT,
        ST_DONE    = SER_DONE,
        ST_ILLEGAL = 2'd3
    } ser_state_e;

endpackage

// File: rtl/digest_serializer_if.sv
// digest_serializer_if -- parallel load side plus bit-serial transmit side of
// the digest serializer.
//   load / digest_in / load_ready : digest capture handshake
//   enable                        : downstream ready for the serial stream
//   serial_out / serial_valid     : serial data bit and its valid
//   serial_end_signal             : marks the last bit of a frame
//   tx_done                       : one-cycle pulse after the last bit
// Modports: master = serializer side, slave = producer/consumer side.
// Macro DIGEST_SER_MSB_FIRST_EN (optional) has no effect on this interface.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where the sender's valid (load, serial_valid) and the receiver's ready
// (load_ready, enable) are both high; a sender keeps its data stable until
// that edge and never makes valid depend combinationally on ready.
interface digest_serializer_if
    import cshake_pkg::*;
#(
    parameter int OUT_BITS = OUT_BITS_DEFAULT
);
    logic                load;
    logic [OUT_BITS-1:0] digest_in;
    logic                load_ready;
    logic                enable;
    logic                serial_out;
    logic                serial_valid;
    logic                serial_end_signal;
    logic                tx_done;

    modport master (
        input  load, digest_in, enable,
        output load_ready, serial_out, serial_valid, serial_end_signal, tx_done
    );

    modport slave (
        output load, digest_in, enable,
        input  load_ready, serial_out, serial_valid, serial_end_signal, tx_done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// piso_shift_reg -- parallel-load, serial-out shift register.
//   clk, reset : clock, synchronous active-high reset (clears the register)
//   load       : capture par_in (has priority over shift_en)
//   shift_en   : advance one bit, zero fill
//   par_in     : parallel data, OUT_BITS wide
//   ser_out    : current output bit
// Macro DIGEST_SER_MSB_FIRST_EN: defined -> output MSB, shift left;
// undefined (default) -> output LSB, shift right.
module piso_shift_reg #(
    parameter int OUT_BITS = 512
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                shift_en,
    input  logic [OUT_BITS-1:0] par_in,
    output logic                ser_out
);

    logic [OUT_BITS-1:0] shreg_d;
    logic [OUT_BITS-1:0] shreg_q;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = par_in;
        end else if (shift_en) begin
`ifdef DIGEST_SER_MSB_FIRST_EN
            shreg_d = {shreg_q[OUT_BITS-2:0], 1'b0};
`else
            shreg_d = {1'b0, shreg_q[OUT_BITS-1:1]};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

`ifdef DIGEST_SER_MSB_FIRST_EN
    assign ser_out = shreg_q[OUT_BITS-1];
`else
    assign ser_out = shreg_q[0];
`endif

endmodule

// File: rtl/digest_serializer.sv
// digest_serializer -- captures the cSHAKE256 digest when the hash core
// signals done and transmits it one bit per accepted cycle.
//   clk, reset          : clock, synchronous active-high reset
//   bus (master)        : load/digest_in/load_ready capture handshake,
//                         serial_out/serial_valid/enable serial handshake,
//                         serial_end_signal on the last bit, tx_done pulse
//   debug_ser_state     : FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//   debug_ser_bitcount  : bits already transferred in the current frame
// Macro DIGEST_SER_MSB_FIRST_EN: defined -> MSB first; default LSB first.
// All outputs decode from registered state only (Moore); enable and load
// only steer next-state logic.
module digest_serializer
    import cshake_pkg::*;
#(
    parameter int OUT_BITS = OUT_BITS_DEFAULT,
    parameter int CNT_W    = $clog2(OUT_BITS)
) (
    input  logic                   clk,
    input  logic                   reset,
    digest_serializer_if.master    bus,
    output logic [1:0]             debug_ser_state,
    output logic [CNT_W-1:0]       debug_ser_bitcount
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_BITS - 1);

    ser_state_e       state_d;
    ser_state_e       state_q;
    logic [CNT_W-1:0] bitcount_d;
    logic [CNT_W-1:0] bitcount_q;
    logic             load_acc;
    logic             shift_en;
    logic             ser_bit;

    piso_shift_reg #(
        .OUT_BITS (OUT_BITS)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (load_acc),
        .shift_en (shift_en),
        .par_in   (bus.digest_in),
        .ser_out  (ser_bit)
    );

    always_comb begin
        state_d    = state_q;
        bitcount_d = bitcount_q;
        load_acc   = 1'b0;
        shift_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    load_acc   = 1'b1;
                    bitcount_d = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.enable) begin
                    shift_en = 1'b1;
                    // Counter saturates at the last index so it never wraps.
                    if (bitcount_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        bitcount_d = bitcount_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bitcount_q <= '0;
        end else begin
            state_q    <= state_d;
            bitcount_q <= bitcount_d;
        end
    end

    assign bus.load_ready        = (state_q == ST_IDLE);
    assign bus.serial_valid      = (state_q == ST_SHIFT);
    assign bus.serial_out        = (state_q == ST_SHIFT) && ser_bit;
    assign bus.serial_end_signal = (state_q == ST_SHIFT) && (bitcount_q == LAST_IDX);
    assign bus.tx_done           = (state_q == ST_DONE);

    assign debug_ser_state    = state_q;
    assign debug_ser_bitcount = bitcount_q;

endmodule

// File: tb/tb_digest_serializer.sv
// tb_digest_serializer -- scoreboard bench for digest_serializer.
// Build with DIGEST_SER_MSB_FIRST_EN defined to check the MSB-first variant.
module tb_digest_serializer;
    import cshake_pkg::*;

    localparam int OB = OUT_BITS_DEFAULT;
    localparam int CW = $clog2(OB);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    digest_serializer_if #(.OUT_BITS(OB)) bus ();
    logic [1:0]    dbg_state;
    logic [CW-1:0] dbg_cnt;

    digest_serializer #(.OUT_BITS(OB)) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus),
        .debug_ser_state    (dbg_state),
        .debug_ser_bitcount (dbg_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [1:0] exp_q[$];   // {end_flag, bit}
    int total = 0;
    int bad   = 0;
    int pending = 0;        // frames whose tx_done is still owed

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OB-1:0] rand_digest();
        logic [OB-1:0] r;
        for (int i = 0; i < OB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: the frame is just the digest bits in wire order.
    task automatic model_push(input logic [OB-1:0] d);
        logic b;
        for (int i = 0; i < OB; i++) begin
`ifdef DIGEST_SER_MSB_FIRST_EN
            b = d[OB-1-i];
`else
            b = d[i];
`endif
            exp_q.push_back({(i == OB - 1), b});
        end
        pending++;
    endtask

    // ---------------- monitor ----------------
    logic [1:0] mon_e;
    int         mon_idx;
    always @(negedge clk) begin
        if (!reset) begin
            check("end_without_valid", bus.serial_end_signal & ~bus.serial_valid, 1'b0);
            if (bus.serial_valid && bus.enable) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 1'b1, 1'b0);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_idx = OB - 1 - exp_q.size();
                    check("serial_out", bus.serial_out, mon_e[0]);
                    check("serial_end", bus.serial_end_signal, mon_e[1]);
                    check("bitcount", dbg_cnt, mon_idx);
                end
            end
            if (bus.tx_done) begin
                check("done_queue_empty", exp_q.size(), 0);
                check("done_expected", (pending > 0), 1'b1);
                if (pending > 0) pending--;
            end
        end
    end

    // ---------------- driver ----------------
    // mode 0: enable held high, 1: enable high on even cycles, 2: random.
    // Cycle 1 is the first cycle after the load edge.
    task automatic send_frame(input logic [OB-1:0] d, input int mode, input int exp_done,
                              input int collide_cyc, input int abort_cyc);
        int cyc;
        int done_cyc;
        int n;
        n = 0;
        while (!bus.load_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("load_ready_before_load", bus.load_ready, 1'b1);
        bus.load      = 1'b1;
        bus.digest_in = d;
        model_push(d);
        @(posedge clk); #1;
        bus.load      = 1'b0;
        bus.digest_in = rand_digest();  // must not be resampled
        cyc      = 1;
        done_cyc = 0;
        while (1) begin
            case (mode)
                0:       bus.enable = 1'b1;
                1:       bus.enable = (cyc % 2 == 0);
                default: bus.enable = 1'($urandom_range(0, 1));
            endcase
            if (cyc == collide_cyc) begin
                bus.load      = 1'b1;
                bus.digest_in = OB'('hA5);
                check("load_ready_busy", bus.load_ready, 1'b0);
            end else begin
                bus.load = 1'b0;
            end
            if (cyc == abort_cyc) reset = 1'b1;
            @(negedge clk);
            if (bus.tx_done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc > 4 * OB + 20) begin
                check("frame_timeout", 1'b1, 1'b0);
                break;
            end
            @(posedge clk); #1;
            if (cyc == abort_cyc) begin
                reset      = 1'b0;
                bus.enable = 1'b0;
                bus.load   = 1'b0;
                check("abort_serial_valid", bus.serial_valid, 1'b0);
                check("abort_load_ready", bus.load_ready, 1'b1);
                check("abort_state", dbg_state, SER_IDLE);
                check("abort_bitcount", dbg_cnt, 0);
                check("abort_tx_done", bus.tx_done, 1'b0);
                exp_q.delete();
                pending = 0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("abort_no_done", bus.tx_done | bus.serial_end_signal, 1'b0);
                end
                @(posedge clk); #1;
                return;
            end
            cyc++;
        end
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        check("load_ready_in_done", bus.load_ready, 1'b0);
        if (exp_done > 0) check("done_cycle", done_cyc, exp_done);
        @(posedge clk); #1;
        check("load_ready_after_done", bus.load_ready, 1'b1);
        check("tx_done_one_cycle", bus.tx_done, 1'b0);
        check("state_idle_after_done", dbg_state, SER_IDLE);
    endtask

    // ---------------- stimulus ----------------
    logic [OB-1:0] one_d;
    logic [OB-1:0] half_d;
    logic [OB-1:0] msb_d;

    initial begin
        reset         = 1'b1;
        bus.load      = 1'b0;
        bus.enable    = 1'b0;
        bus.digest_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_load_ready", bus.load_ready, 1'b1);
        check("rst_serial_valid", bus.serial_valid, 1'b0);
        check("rst_serial_out", bus.serial_out, 1'b0);
        check("rst_serial_end", bus.serial_end_signal, 1'b0);
        check("rst_tx_done", bus.tx_done, 1'b0);
        check("rst_state", dbg_state, SER_IDLE);
        check("rst_bitcount", dbg_cnt, 0);

        one_d  = OB'(1);
        half_d = {{(OB/2){1'b0}}, {(OB/2){1'b1}}};
        msb_d  = '0;
        msb_d[OB-1] = 1'b1;

        send_frame(one_d, 0, OB + 1, 0, 0);            // basic frame
        send_frame(half_d, 0, OB + 1, 0, 0);           // pattern and end marker
        send_frame(one_d, 1, 2 * OB + 1, 0, 0);        // backpressure
        send_frame(rand_digest(), 0, OB + 1, 50, 0);   // load collision
        send_frame(rand_digest(), 0, 0, 0, 101);       // reset at bitcount 100
        send_frame(rand_digest(), 0, OB + 1, 0, 0);    // clean frame after reset
        send_frame(msb_d, 0, OB + 1, 0, 0);            // MSB set
        for (int f = 0; f < 4; f++) begin
            send_frame(rand_digest(), 2, 0, 0, 0);     // random backpressure
        end

        repeat (3) @(posedge clk);
        #1;
        check("end_queue_empty", exp_q.size(), 0);
        check("end_pending", pending, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
